wb_rx_frame_buffer: RTL

- Receive-side stage directly downstream of the 10-bit deserializer.
- Takes 9-bit {k, byte} words handed over from the CLK_NEWFREQ domain by toggle handshake.
- Aligns them on a comma K-code and assembles 27-bit frames in the same [k+8][k+8][k+8] layout the transmit serializer sends.
- Buffers frames in a small FIFO that a Wishbone master reads; status and error flags live in a second register.

---
 rtl/wb_rx_frame_buffer_pkg.sv | 23 ++
 rtl/wb_rx_frame_buffer_tgl_sync.sv | 30 +++
 rtl/wb_rx_frame_buffer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_rx_frame_buffer_pkg.sv
// rtl/wb_rx_frame_buffer_pkg.sv - shared constants and types for the rx frame buffer
package wb_rx_frame_buffer_pkg;

    localparam logic [1:0] ADR_DATA = 2'd0;
    localparam logic [1:0] ADR_STAT = 2'd1;
    localparam int         NUM_REGS = 2;

    localparam logic [7:0] K_COMMA = 8'hBC;
    localparam int         FRAME_W = 27;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_FERR  = 3;
    localparam int STAT_CERR  = 4;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        W1   = 2'd1,
        W2   = 2'd2
    } asm_state_e;

endpackage

// File: rtl/wb_rx_frame_buffer_tgl_sync.sv
// rtl/wb_rx_frame_buffer_tgl_sync.sv - toggle synchronizer producing a one-cycle pulse per toggle
module tgl_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK_I,
    input  logic RST_NEWFREQ_I,
    input  logic tgl_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], tgl_i};
        hist_d  = sync_q[SYNC_STAGES-1];
        pulse_o = sync_q[SYNC_STAGES-1] ^ hist_q;
    end

    always_ff @(posedge CLK_I or posedge RST_NEWFREQ_I) begin
        if (RST_NEWFREQ_I) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/wb_rx_frame_buffer.sv
// rtl/wb_rx_frame_buffer.sv - comma-aligned 27-bit frame assembler with Wishbone-read FIFO
module wb_rx_frame_buffer
    import wb_rx_frame_buffer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK_I,
    input  logic        RST_NEWFREQ_I,
    input  logic [8:0]  word_i,
    input  logic        word_tgl_i,
    input  logic        cerr_tgl_i,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic        ERR_O,
    output logic [31:0] DAT_O,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic word_pulse, cerr_pulse;

    tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_word_sync (
        .CLK_I         (CLK_I),
        .RST_NEWFREQ_I (RST_NEWFREQ_I),
        .tgl_i         (word_tgl_i),
        .pulse_o       (word_pulse)
    );

    tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cerr_sync (
        .CLK_I         (CLK_I),
        .RST_NEWFREQ_I (RST_NEWFREQ_I),
        .tgl_i         (cerr_tgl_i),
        .pulse_o       (cerr_pulse)
    );

    asm_state_e         state_q, state_d;
    logic [8:0]         word0_q, word0_d, word1_q, word1_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               push_q, push_d;
    logic               ferr_set;
    logic               is_comma;

    logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count;
    logic               empty, full, pop, push_ok;
    logic               cerr_q, cerr_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [2:0]         clr;
    logic [7:0]         count8;
    logic [31:0]        stat;
    logic               unused_ok;

    assign is_comma = (word_i == {1'b1, K_COMMA});

    always_ff @(posedge CLK_I or posedge RST_NEWFREQ_I) begin
        if (RST_NEWFREQ_I) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (word_pulse) begin
            case (state_q)
                HUNT:    state_d = is_comma ? W1 : HUNT;
                W1:      state_d = is_comma ? W1 : W2;
                W2:      state_d = is_comma ? W1 : HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // A comma seen mid-frame means the previous alignment was wrong: restart on it
    always_comb begin
        word0_d  = word0_q;
        word1_d  = word1_q;
        frame_d  = frame_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        if (word_pulse) begin
            case (state_q)
                HUNT: begin
                    if (is_comma) word0_d = word_i;
                end
                W1: begin
                    if (is_comma) begin
                        word0_d  = word_i;
                        ferr_set = 1'b1;
                    end else begin
                        word1_d = word_i;
                    end
                end
                W2: begin
                    if (is_comma) begin
                        word0_d  = word_i;
                        ferr_set = 1'b1;
                    end else begin
                        frame_d = {word0_q, word1_q, word_i};
                        push_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign count8  = 8'(count);
    assign push_ok = push_q & (~full | pop);

    always_comb begin
        stat             = '0;
        stat[15:8]       = count8;
        stat[STAT_CERR]  = cerr_q;
        stat[STAT_FERR]  = ferr_q;
        stat[STAT_OVF]   = ovf_q;
        stat[STAT_FULL]  = full;
        stat[STAT_EMPTY] = empty;
    end

    always_comb begin
        ACK_O = 1'b0;
        ERR_O = 1'b0;
        DAT_O = '0;
        pop   = 1'b0;
        clr   = '0;
        if (CYC_I & STB_I) begin
            case (ADR_I[1:0])
                ADR_DATA: begin
                    if (WE_I || empty) begin
                        ERR_O = 1'b1;
                    end else begin
                        ACK_O = 1'b1;
                        DAT_O = {5'b0, mem_q[rd_ptr_q[AW-1:0]]};
                        pop   = 1'b1;
                    end
                end
                ADR_STAT: begin
                    ACK_O = 1'b1;
                    if (WE_I) clr = DAT_I[4:2];
                    else      DAT_O = stat;
                end
                default: ERR_O = 1'b1;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = frame_q;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        cerr_d = (cerr_q & ~clr[2]) | cerr_pulse;
        ferr_d = (ferr_q & ~clr[1]) | ferr_set;
        ovf_d  = (ovf_q  & ~clr[0]) | (push_q & ~push_ok);
    end

    always_ff @(posedge CLK_I or posedge RST_NEWFREQ_I) begin
        if (RST_NEWFREQ_I) begin
            word0_q  <= '0;
            word1_q  <= '0;
            frame_q  <= '0;
            push_q   <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cerr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            word0_q  <= word0_d;
            word1_q  <= word1_d;
            frame_q  <= frame_d;
            push_q   <= push_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cerr_q   <= cerr_d;
            ferr_q   <= ferr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign irq_o = ~empty | cerr_q | ferr_q | ovf_q;

    assign unused_ok = ^{ADR_I[31:2], DAT_I[31:5], DAT_I[1:0]};

endmodule
